// File: rtl/sys_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the system bus decoder.
interface sys_bus_arbiter_if;
    logic        m0_req;
    logic        m0_lock;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_wen;
    logic        m0_ack;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_wen;
    logic        m1_ack;
    logic [31:0] m1_rdata;

    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wen;
    logic [31:0] bus_rdata;

    logic        grant_id;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_wdata, m0_wen,
        input  m1_req, m1_lock, m1_addr, m1_wdata, m1_wen,
        input  bus_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output bus_addr, bus_wdata, bus_wen, grant_id
    );

    // Masters plus decoder side.
    modport master (
        output m0_req, m0_lock, m0_addr, m0_wdata, m0_wen,
        output m1_req, m1_lock, m1_addr, m1_wdata, m1_wen,
        output bus_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  bus_addr, bus_wdata, bus_wen, grant_id
    );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin system bus arbiter with bounded lock (bus hold) support.
// Each transaction is IDLE -> ACCESS -> RESP; locked masters skip IDLE.
module sys_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sys_bus_arbiter_if.slave  bus_if
);

    localparam int unsigned DW = 32;
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wen;
    } cmd_t;

    state_e        state_q, state_d;
    cmd_t          bus_q,   bus_d;
    logic          grant_q, grant_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic          ack0_q,  ack0_d;
    logic          ack1_q,  ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    cmd_t          cmd0_c, cmd1_c;
    logic          win_c;
    logic          own_req_c, own_lock_c, other_req_c;
    logic [DW-1:0] rd_c;

    assign cmd0_c = '{addr: bus_if.m0_addr, wdata: bus_if.m0_wdata, wen: bus_if.m0_wen};
    assign cmd1_c = '{addr: bus_if.m1_addr, wdata: bus_if.m1_wdata, wen: bus_if.m1_wen};

    // On a tie the master that did not own the bus last wins.
    assign win_c = (bus_if.m0_req && bus_if.m1_req) ? ~grant_q : bus_if.m1_req;

    assign own_req_c   = grant_q ? bus_if.m1_req  : bus_if.m0_req;
    assign own_lock_c  = grant_q ? bus_if.m1_lock : bus_if.m0_lock;
    assign other_req_c = grant_q ? bus_if.m0_req  : bus_if.m1_req;

    assign rd_c = bus_q.wen ? '0 : bus_if.bus_rdata;

    always_comb begin
        state_d  = state_q;
        bus_d    = '0;
        grant_d  = grant_q;
        hold_d   = hold_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = '0;
        rdata1_d = '0;

        unique case (state_q)
            IDLE: begin
                if (bus_if.m0_req || bus_if.m1_req) begin
                    state_d = ACCESS;
                    grant_d = win_c;
                    bus_d   = win_c ? cmd1_c : cmd0_c;
                    if (win_c != grant_q) begin
                        hold_d = HW'(1);
                    end
                end
            end

            ACCESS: begin
                state_d = RESP;
                if (grant_q) begin
                    ack1_d   = 1'b1;
                    rdata1_d = rd_c;
                end else begin
                    ack0_d   = 1'b1;
                    rdata0_d = rd_c;
                end
            end

            RESP: begin
                state_d = IDLE;
                // Lock is bounded only while the other master is waiting.
                if (own_req_c && own_lock_c &&
                    (!other_req_c || (hold_q < HW'(MAX_HOLD)))) begin
                    state_d = ACCESS;
                    bus_d   = grant_q ? cmd1_c : cmd0_c;
                    if (hold_q < HW'(MAX_HOLD)) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bus_q    <= '0;
            grant_q  <= 1'b1;
            hold_q   <= HW'(1);
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            grant_q  <= grant_d;
            hold_q   <= hold_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus_if.bus_addr  = bus_q.addr;
    assign bus_if.bus_wdata = bus_q.wdata;
    assign bus_if.bus_wen   = bus_q.wen;
    assign bus_if.m0_ack    = ack0_q;
    assign bus_if.m1_ack    = ack1_q;
    assign bus_if.m0_rdata  = rdata0_q;
    assign bus_if.m1_rdata  = rdata1_q;
    assign bus_if.grant_id  = grant_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter: expected transactions are queued when
// requests are driven and retired in order as acks appear.
module tb_sys_bus_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic clk;
    logic rst_n;

    sys_bus_arbiter_if bus_if();

    sys_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gap;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wen_pulses = 0;
    int          last_ack_cyc = 0;
    int          lb_cyc = 0;
    logic [31:0] lb_addr = '0;
    logic [31:0] lb_wdata = '0;
    logic        lb_wen = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h1000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Decoder model: combinational read data.
    always_comb bus_if.bus_rdata = (bus_if.bus_addr == '0) ? '0 : mem_rd(bus_if.bus_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit id, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gap);
        exp_t e;
        e.id    = id;
        e.wen   = wen;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = wen ? 32'h0 : mem_rd(addr);
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    task automatic set_m(input bit id, input bit req, input bit lock, input bit wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (id) begin
            bus_if.m1_req = req; bus_if.m1_lock = lock; bus_if.m1_wen = wen;
            bus_if.m1_addr = addr; bus_if.m1_wdata = wdata;
        end else begin
            bus_if.m0_req = req; bus_if.m0_lock = lock; bus_if.m0_wen = wen;
            bus_if.m0_addr = addr; bus_if.m0_wdata = wdata;
        end
    endtask

    // Returns on the falling edge of the n-th ack of master id.
    task automatic wait_acks(input bit id, input int n, output int at_cyc);
        int seen = 0;
        for (int t = 0; t < 300 && seen < n; t++) begin
            @(negedge clk);
            if (id ? bus_if.m1_ack : bus_if.m0_ack) seen++;
        end
        if (seen < n) check("ack_timeout", 32'(seen), 32'(n));
        at_cyc = cyc;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_grant_id", 32'(bus_if.grant_id), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: bus cycles and acks, sampled on the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus_if.m0_ack && bus_if.m1_ack) check("dual_ack", 32'd1, 32'd0);
        if (bus_if.bus_addr != '0 || bus_if.bus_wen) begin
            lb_addr  = bus_if.bus_addr;
            lb_wdata = bus_if.bus_wdata;
            lb_wen   = bus_if.bus_wen;
            lb_cyc   = cyc;
            if (bus_if.bus_wen) wen_pulses++;
        end
        if (bus_if.m0_ack || bus_if.m1_ack) begin
            if (sb_q.size() == 0) begin
                check("ack_expected", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("ack_id", 32'(bus_if.m1_ack), 32'(e.id));
                check("rdata", e.id ? bus_if.m1_rdata : bus_if.m0_rdata, e.rdata);
                check("loser_rdata", e.id ? bus_if.m0_rdata : bus_if.m1_rdata, 32'h0);
                check("bus_addr", lb_addr, e.addr);
                check("bus_wen", 32'(lb_wen), 32'(e.wen));
                if (e.wen) check("bus_wdata", lb_wdata, e.wdata);
                if (e.gap != 0) check("ack_gap", 32'(cyc - last_ack_cyc), 32'(e.gap));
            end
            last_ack_cyc = cyc;
        end
    end

    initial begin
        int t0, ta, p0;
        rst_n = 1'b0;
        set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m0_ack",    32'(bus_if.m0_ack), 32'd0);
        check("rst_m1_ack",    32'(bus_if.m1_ack), 32'd0);
        check("rst_m0_rdata",  bus_if.m0_rdata, 32'h0);
        check("rst_m1_rdata",  bus_if.m1_rdata, 32'h0);
        check("rst_bus_addr",  bus_if.bus_addr, 32'h0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_bus_wen",   32'(bus_if.bus_wen), 32'd0);
        check("rst_grant_id",  32'(bus_if.grant_id), 32'd1);
        rst_n = 1'b1;

        // Single m0 write
        @(posedge clk); #1;
        p0 = wen_pulses;
        push(1'b0, 1'b1, 32'h2000_0000, 32'h0000_00A5, 0);
        set_m(1'b0, 1'b1, 1'b0, 1'b1, 32'h2000_0000, 32'h0000_00A5);
        t0 = cyc;
        wait_acks(1'b0, 1, ta);
        set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("wr_latency", 32'(ta - t0), 32'd2);
        check("wr_access_cyc", 32'(lb_cyc - t0), 32'd1);
        check("wr_wen_pulses", 32'(wen_pulses - p0), 32'd1);

        // Single m1 read
        @(posedge clk); #1;
        push(1'b1, 1'b0, 32'h1000_0010, 32'h0, 0);
        set_m(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0010, 32'h0);
        t0 = cyc;
        wait_acks(1'b1, 1, ta);
        set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("rd_latency", 32'(ta - t0), 32'd2);
        check("rd_grant_id", 32'(bus_if.grant_id), 32'd1);

        // Both masters continuous, no lock: strict alternation every 3 cycles
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            if (i[0]) push(1'b1, 1'b1, 32'h3000_0200, 32'h1234_5678, 3);
            else      push(1'b0, 1'b0, 32'h3000_0100, 32'h0, (i == 0) ? 0 : 3);
        end
        set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000_0100, 32'h0);
        set_m(1'b1, 1'b1, 1'b0, 1'b1, 32'h3000_0200, 32'h1234_5678);
        wait_acks(1'b1, 3, ta);
        set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // m1 lock with m0 waiting: MAX_HOLD grants, then m0, then unbounded m1
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 32'h4000_0040, 32'h0, (i == 0) ? 0 : 2);
        push(1'b0, 1'b1, 32'h4000_0080, 32'h0BAD_CAFE, 3);
        for (int i = 0; i < 6; i++) push(1'b1, 1'b0, 32'h4000_0040, 32'h0, (i == 0) ? 3 : 2);
        set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0040, 32'h0);
        @(posedge clk); #1;
        set_m(1'b0, 1'b1, 1'b0, 1'b1, 32'h4000_0080, 32'h0BAD_CAFE);
        wait_acks(1'b0, 1, ta);
        set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        wait_acks(1'b1, 6, ta);
        set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset during ACCESS of an m0 write
        @(posedge clk); #1;
        push(1'b0, 1'b1, 32'h5000_0000, 32'hCAFE_F00D, 0);
        set_m(1'b0, 1'b1, 1'b0, 1'b1, 32'h5000_0000, 32'hCAFE_F00D);
        for (int t = 0; t < 20 && !bus_if.bus_wen; t++) @(negedge clk);
        check("abort_in_access", 32'(bus_if.bus_wen), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_bus_wen",   32'(bus_if.bus_wen), 32'd0);
        check("abort_bus_addr",  bus_if.bus_addr, 32'h0);
        check("abort_bus_wdata", bus_if.bus_wdata, 32'h0);
        @(posedge clk); #1;
        check("abort_no_ack", 32'(bus_if.m0_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = wen_pulses;
        wait_acks(1'b0, 1, ta);
        set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("abort_wen_pulses", 32'(wen_pulses - p0), 32'd1);

        // m1 request withdrawn while m0 owns the bus: no m1 bus cycle
        @(posedge clk); #1;
        push(1'b0, 1'b0, 32'h6000_0004, 32'h0, 0);
        set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h6000_0004, 32'h0);
        @(posedge clk); #1;
        set_m(1'b1, 1'b1, 1'b0, 1'b1, 32'h6000_0008, 32'h7777_0000);
        p0 = wen_pulses;
        wait_acks(1'b0, 1, ta);
        set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (6) @(posedge clk);
        #1;
        check("drop_wen_pulses", 32'(wen_pulses - p0), 32'd0);
        check("drop_bus_addr", bus_if.bus_addr, 32'h0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sys_bus_arbiter.md
SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16: maximum consecutive locked grants to one master while the other master is requesting.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports m0_req / m1_req  input  1  transaction request, master 0 (CPU) / master 1 (loader/DMA).
REQ-005 The block SHALL have ports m0_lock / m1_lock  input  1  master requests to keep the bus for its next transaction.
REQ-006 The block SHALL have ports m0_addr / m1_addr  input  32  transaction address.
REQ-007 The block SHALL have ports m0_wdata / m1_wdata  input  32  write data.
REQ-008 The block SHALL have ports m0_wen / m1_wen  input  1  1 = write, 0 = read.
REQ-009 The block SHALL have ports m0_ack / m1_ack  output  1  one-cycle transaction-complete pulse.
REQ-010 The block SHALL have ports m0_rdata / m1_rdata  output  32  read data, valid while the matching ack = 1.
REQ-011 The block SHALL have ports bus_addr, bus_wdata  output  32  to the system bus decoder; and bus_wen  output  1  its write enable.
REQ-012 The block SHALL have port bus_rdata  input  32  combinational read data from the system bus decoder.
REQ-013 The block SHALL have port grant_id  output  1  master currently owning or last owning the bus.

Function
REQ-014 Masters SHALL hold req, addr, wdata, wen and lock stable from req assertion until their ack; the arbiter SHALL register addr/wdata/wen on grant and SHALL NOT re-sample them before ack.
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-016 IDLE: no request -> stay IDLE; any request -> select a winner, latch its command, go to ACCESS.
REQ-017 ACCESS SHALL last exactly one cycle: bus_addr/bus_wdata driven from the latch; bus_wen = latched wen; bus_rdata registered at the end of the cycle; next state RESP.
REQ-018 RESP SHALL last exactly one cycle: winner's ack = 1, winner's rdata = registered value (0 for writes); next state IDLE, except when the lock continuation in REQ-021 applies.
REQ-019 Outside ACCESS, bus_addr, bus_wdata and bus_wen SHALL be 0; at most one bus_wen pulse per transaction.
REQ-020 Arbitration SHALL be round-robin: if both request, the master other than grant_id wins; if one requests, it wins.
REQ-021 If in RESP the winner has lock = 1 and req = 1, and hold_cnt < MAX_HOLD, the FSM SHALL go directly to ACCESS for the same master, relatching its command, and increment hold_cnt.
REQ-022 hold_cnt SHALL reset to 1 on every change of owner; when the other master is requesting and hold_cnt = MAX_HOLD, lock SHALL be ignored and the FSM SHALL go to IDLE (round-robin then selects the other master). When the other master is not requesting, lock SHALL be honoured without limit; hold_cnt SHALL saturate and not wrap.
REQ-023 Latency: request seen in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2; unlocked back-to-back throughput is one transaction per 3 cycles; locked throughput is one per 2 cycles.
REQ-024 m0_ack and m1_ack SHALL never be 1 in the same cycle; the non-winning master's rdata SHALL be 0.
REQ-025 A request deasserted while its master is not granted SHALL be dropped without a bus cycle.

Reset
REQ-026 rst_n = 0 SHALL immediately force: state IDLE; acks 0; rdata 0; bus_* 0; grant_id 1 (so m0 wins the first tie); hold_cnt 1.
REQ-027 Reset asserted during ACCESS or RESP SHALL abort the transaction without ack; after release, a still-asserted request SHALL be served as new.

Verification
REQ-028 m0 write addr 0x2000_0000, data 0x0000_00A5 from IDLE -> bus_wen = 1 for exactly one cycle at N+1 with matching addr/data; m0_ack = 1 at N+2, m0_rdata = 0.
REQ-029 m1 read 0x1000_0010 with bus_rdata = 0xDEAD_BEEF -> m1_ack at N+2, m1_rdata = 0xDEAD_BEEF, m0_ack = 0 throughout.
REQ-030 m0 and m1 both requesting continuously, no lock, starting after reset -> grants alternate m0, m1, m0, m1; ack every 3 cycles.
REQ-031 m1 lock = 1, m0 requesting, MAX_HOLD = 4 -> 4 consecutive m1 transactions 2 cycles apart, then an m0 transaction; with m0 idle, m1 keeps the bus beyond 4 transactions.
REQ-032 rst_n pulsed low during ACCESS of an m0 write -> bus_* = 0 immediately, no m0_ack; after release, the held request completes once with one bus_wen pulse.
